// File: rtl/led_ctrl_pkg.sv
// Shared mode codes, FSM state encoding and shift-direction constants for the
// LED pattern sequencer and its helpers.
package led_ctrl_pkg;

  localparam logic [2:0] MODE_OFF    = 3'd0;
  localparam logic [2:0] MODE_ROT_L  = 3'd1;
  localparam logic [2:0] MODE_ROT_R  = 3'd2;
  localparam logic [2:0] MODE_BOUNCE = 3'd3;
  localparam logic [2:0] MODE_BLINK  = 3'd4;
  localparam logic [2:0] MODE_COUNT  = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  // Codes 6 and 7 are reserved and behave exactly like OFF.
  function automatic logic is_pattern_mode(input logic [2:0] m);
    return (m >= MODE_ROT_L) && (m <= MODE_COUNT);
  endfunction

endpackage

// File: rtl/led_tick_gen.sv
// Step-rate prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
module led_tick_gen #(
  parameter int TICK_DIV = 25000000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_WIDTH = $clog2(TICK_DIV);
  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(TICK_DIV - 1);

  logic [CNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    tick    = en && (count_q == LAST);
    count_d = count_q;
    if (clr || tick) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/led_pattern_sequencer.sv
// Drives the LED register through rotate/bounce/blink/count animations, with
// modes loaded over a valid/ready handshake and steps paced by led_tick_gen.
module led_pattern_sequencer
  import led_ctrl_pkg::*;
#(
  parameter int LED_WIDTH = 4,
  parameter int TICK_DIV  = 25000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [2:0]           mode,
  input  logic                 mode_valid,
  output logic                 mode_ready,
  output logic [LED_WIDTH-1:0] leds,
  output logic                 step_pulse,
  output logic                 active
);

  state_e               state_q, state_d;
  logic [2:0]           mode_q, mode_d;
  logic [LED_WIDTH-1:0] leds_q, leds_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 active_q, active_d;
  logic                 accept;
  logic                 tick;
  logic                 tick_clr;
  logic [LED_WIDTH-1:0] bounce_shift;

  function automatic logic [LED_WIDTH-1:0] seed_of(input logic [2:0] m);
    case (m)
      MODE_ROT_L, MODE_BOUNCE: seed_of = LED_WIDTH'(1);
      MODE_ROT_R:              seed_of = {1'b1, {(LED_WIDTH-1){1'b0}}};
      MODE_BLINK:              seed_of = '1;
      default:                 seed_of = '0;
    endcase
  endfunction

  led_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .clr   (tick_clr),
    .en    (en && (state_q == ST_RUN)),
    .tick  (tick)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    leds_d       = leds_q;
    dir_d        = dir_q;
    step_d       = 1'b0;
    tick_clr     = 1'b0;
    accept       = mode_valid && (state_q != ST_LOAD);
    bounce_shift = (dir_q == DIR_LEFT) ? (leds_q << 1) : (leds_q >> 1);

    case (state_q)
      ST_IDLE: begin
        leds_d = '0;
        if (accept) begin
          state_d = ST_LOAD;
          mode_d  = mode;
        end
      end
      ST_LOAD: begin
        leds_d   = seed_of(mode_q);
        dir_d    = DIR_LEFT;
        tick_clr = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        // A new mode takes priority over a coincident tick; that step is dropped.
        if (accept) begin
          state_d = ST_LOAD;
          mode_d  = mode;
        end else if (!is_pattern_mode(mode_q)) begin
          leds_d = '0;
        end else if (tick) begin
          step_d = 1'b1;
          case (mode_q)
            MODE_ROT_L: leds_d = {leds_q[LED_WIDTH-2:0], leds_q[LED_WIDTH-1]};
            MODE_ROT_R: leds_d = {leds_q[0], leds_q[LED_WIDTH-1:1]};
            MODE_BOUNCE: begin
              leds_d = bounce_shift;
              if (bounce_shift[LED_WIDTH-1]) begin
                dir_d = DIR_RIGHT;
              end else if (bounce_shift[0]) begin
                dir_d = DIR_LEFT;
              end
            end
            MODE_BLINK: leds_d = ~leds_q;
            default:    leds_d = leds_q + LED_WIDTH'(1);
          endcase
        end
      end
      default: begin
        state_d = ST_IDLE;
        leds_d  = '0;
      end
    endcase

    active_d = (state_d == ST_RUN) && is_pattern_mode(mode_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_OFF;
      leds_q   <= '0;
      dir_q    <= DIR_LEFT;
      step_q   <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      leds_q   <= leds_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      active_q <= active_d;
    end
  end

  assign mode_ready = (state_q != ST_LOAD);
  assign leds       = leds_q;
  assign step_pulse = step_q;
  assign active     = active_q;

endmodule

// File: tb/tb_led_pattern_sequencer.sv
// Randomised and directed bench for led_pattern_sequencer (LED_WIDTH=4,
// TICK_DIV=4) against a closed-form behavioural model of the animations.
module tb_led_pattern_sequencer;

  localparam int W   = 4;
  localparam int DIV = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [2:0]   mode;
  logic         mode_valid;
  logic         mode_ready;
  logic [W-1:0] leds;
  logic         step_pulse;
  logic         active;

  int vectors     = 0;
  int miscompares = 0;
  int cycle       = 0;

  // Behavioural model: output of a pattern is a closed-form function of the
  // number of steps taken since the seed.
  int         m_phase = 0;    // 0 idle, 1 loading, 2 running
  int         m_mode  = 0;
  int         m_steps = 0;
  int         m_cnt   = 0;    // enabled running cycles modulo DIV
  logic [3:0] m_leds  = 4'h0;
  logic       m_sp    = 1'b0;
  bit         m_ok    = 1'b0;

  led_pattern_sequencer #(
    .LED_WIDTH (W),
    .TICK_DIV  (DIV)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .mode       (mode),
    .mode_valid (mode_valid),
    .mode_ready (mode_ready),
    .leds       (leds),
    .step_pulse (step_pulse),
    .active     (active)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] pat(input int m, input int k);
    int p;
    case (m)
      1: pat = 4'(1 << (k % 4));
      2: pat = 4'(8 >> (k % 4));
      3: begin
        p = k % 6;
        if (p > 3) p = 6 - p;
        pat = 4'(1 << p);
      end
      4: pat = ((k % 2) == 0) ? 4'hF : 4'h0;
      5: pat = 4'(k % 16);
      default: pat = 4'h0;
    endcase
  endfunction

  function automatic bit is_pat(input int m);
    return (m >= 1) && (m <= 5);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, exp, cycle);
    end
  endtask

  task automatic model_edge();
    bit acc;
    bit tick;
    cycle++;
    if (reset) begin
      m_phase = 0; m_mode = 0; m_steps = 0; m_cnt = 0; m_leds = 4'h0; m_sp = 1'b0;
      m_ok = 1'b1;
    end else if (m_ok) begin
      m_sp = 1'b0;
      acc  = mode_valid && (m_phase != 1);
      if (acc) $display("cycle %0d: accept mode %0d", cycle, mode);
      case (m_phase)
        0: if (acc) begin m_phase = 1; m_mode = int'(mode); end
        1: begin
          m_phase = 2; m_steps = 0; m_cnt = 0; m_leds = pat(m_mode, 0);
        end
        default: begin
          tick = en && (m_cnt == DIV - 1);
          if (en) m_cnt = (m_cnt + 1) % DIV;
          if (acc) begin
            m_phase = 1; m_mode = int'(mode);
          end else if (tick && is_pat(m_mode)) begin
            m_steps++; m_leds = pat(m_mode, m_steps); m_sp = 1'b1;
          end
        end
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_edge();
  end

  initial forever begin
    @(negedge clk);
    if (m_ok) begin
      check("leds", 32'(leds), 32'(m_leds));
      check("step_pulse", 32'(step_pulse), 32'(m_sp));
      check("active", 32'(active), 32'((m_phase == 2) && is_pat(m_mode)));
      check("mode_ready", 32'(mode_ready), 32'(m_phase != 1));
    end
  end

  task automatic load_mode(input logic [2:0] m);
    @(negedge clk);
    mode = m; mode_valid = 1'b1;
    @(negedge clk);
    mode_valid = 1'b0;
  endtask

  task automatic lit(input string name, input logic [3:0] exp_leds, input logic exp_sp);
    check({name, "_leds"}, 32'(leds), 32'(exp_leds));
    check({name, "_sp"}, 32'(step_pulse), 32'(exp_sp));
  endtask

  logic [3:0] bounce_seq [9] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100,
                                 4'b0010, 4'b0001, 4'b0010, 4'b0100};

  initial begin
    reset = 1'b1; en = 1'b1; mode = 3'd1; mode_valid = 1'b1;
    // Reset held with a pending request
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit("reset", 4'h0, 1'b0);
      check("reset_ready", 32'(mode_ready), 32'd1);
      check("reset_active", 32'(active), 32'd0);
    end
    reset = 1'b0; mode_valid = 1'b0;
    repeat (3) @(negedge clk);
    lit("idle", 4'h0, 1'b0);
    check("idle_active", 32'(active), 32'd0);

    // ROT_L: seed one edge after accept, then a step every DIV edges
    load_mode(3'd1);
    @(negedge clk); lit("rotl_seed", 4'b0001, 1'b0);
    check("rotl_active", 32'(active), 32'd1);
    repeat (3) @(negedge clk); lit("rotl_wait", 4'b0001, 1'b0);
    @(negedge clk); lit("rotl_s1", 4'b0010, 1'b1);
    repeat (4) @(negedge clk); lit("rotl_s2", 4'b0100, 1'b1);
    repeat (4) @(negedge clk); lit("rotl_s3", 4'b1000, 1'b1);
    repeat (4) @(negedge clk); lit("rotl_s4", 4'b0001, 1'b1);

    // BOUNCE: ends lit for one step each
    load_mode(3'd3);
    @(negedge clk); lit("bounce_s0", bounce_seq[0], 1'b0);
    for (int i = 1; i < 9; i++) begin
      repeat (4) @(negedge clk);
      lit("bounce_step", bounce_seq[i], 1'b1);
    end

    // COUNT with en dropped mid-count (held count = 2)
    load_mode(3'd5);
    @(negedge clk); lit("count_s0", 4'b0000, 1'b0);
    repeat (8) @(negedge clk); lit("count_s2", 4'b0010, 1'b1);
    repeat (2) @(negedge clk);
    en = 1'b0;
    repeat (10) begin
      @(negedge clk); lit("count_hold", 4'b0010, 1'b0);
    end
    en = 1'b1;
    @(negedge clk); lit("count_resume1", 4'b0010, 1'b0);
    @(negedge clk); lit("count_s3", 4'b0011, 1'b1);
    repeat (48) @(negedge clk); lit("count_s15", 4'b1111, 1'b1);
    repeat (4) @(negedge clk); lit("count_wrap", 4'b0000, 1'b1);

    // Accept coincident with a tick in ROT_R
    load_mode(3'd2);
    @(negedge clk); lit("rotr_seed", 4'b1000, 1'b0);
    repeat (4) @(negedge clk); lit("rotr_s1", 4'b0100, 1'b1);
    repeat (3) @(negedge clk);
    mode = 3'd4; mode_valid = 1'b1;
    @(negedge clk);
    mode_valid = 1'b0;
    lit("collide", 4'b0100, 1'b0);
    check("collide_ready", 32'(mode_ready), 32'd0);
    @(negedge clk); lit("blink_seed", 4'b1111, 1'b0);
    repeat (4) @(negedge clk); lit("blink_s1", 4'b0000, 1'b1);
    repeat (4) @(negedge clk); lit("blink_s2", 4'b1111, 1'b1);

    // Reserved mode, then reset in the middle of a ROT_L step
    load_mode(3'd7);
    @(negedge clk); lit("rsvd", 4'h0, 1'b0);
    check("rsvd_active", 32'(active), 32'd0);
    repeat (8) @(negedge clk); lit("rsvd_later", 4'h0, 1'b0);
    load_mode(3'd1);
    @(negedge clk);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    lit("midreset", 4'h0, 1'b0);
    check("midreset_ready", 32'(mode_ready), 32'd1);
    check("midreset_active", 32'(active), 32'd0);
    load_mode(3'd1);
    @(negedge clk); lit("restart_seed", 4'b0001, 1'b0);
    repeat (3) @(negedge clk); lit("restart_wait", 4'b0001, 1'b0);
    @(negedge clk); lit("restart_s1", 4'b0010, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      reset      = ($urandom_range(0, 249) == 0);
      en         = ($urandom_range(0, 9) != 0);
      mode_valid = ($urandom_range(0, 29) == 0);
      mode       = 3'($urandom_range(0, 7));
    end
    @(negedge clk);
    reset = 1'b0; mode_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/led_pattern_sequencer.md
Name: led_pattern_sequencer

Overview:
Sequences the LED output register through selectable animation patterns (rotate, bounce, blink, binary count) at a programmable step rate. A host loads a mode through a valid/ready handshake. An internal prescaler generates step ticks from the system clock. Sits between the board-level control logic and the LED pins; it is the single owner of the LED state register.

Parameters:
LED_WIDTH, 4, number of LEDs driven; legal range is 2 or more.
TICK_DIV, 25000000, clk cycles per pattern step; legal range is 2 or more.
CNT_WIDTH, $clog2(TICK_DIV), prescaler counter width; derived, not overridden.

Ports:
clk  input  1  system clock; all logic is on the rising edge.
reset  input  1  synchronous, active-high reset.
en  input  1  run enable; 0 freezes the pattern and the prescaler.
mode  input  3  requested pattern code; sampled only on handshake.
mode_valid  input  1  host presents `mode`.
mode_ready  output  1  block can accept a mode this cycle.
leds  output  LED_WIDTH  registered LED drive.
step_pulse  output  1  one-cycle strobe, high in the cycle `leds` shows a new step.
active  output  1  high while state is RUN and the mode is not OFF.

Behaviour:
- Reset (clk, reset: one clock, synchronous, active-high). When `reset`=1 at an edge:
  - state=IDLE, mode_r=OFF, leds=0, step_pulse=0, active=0, mode_ready=1, prescaler=0.
  - Reset asserted mid-sequence overrides everything at that edge.
- Mode codes:
  - 0 OFF: leds=0.
  - 1 ROT_L: seed 0…01, rotate left.
  - 2 ROT_R: seed 10…0, rotate right.
  - 3 BOUNCE: seed 0…01, direction left.
  - 4 BLINK: seed all ones, invert each step.
  - 5 COUNT: seed 0, increment each step modulo 2^LED_WIDTH.
  - 6 and 7 are reserved and are treated as OFF.
- Handshake:
  - Accept occurs when mode_valid && mode_ready at an edge.
  - mode_ready = (state != LOAD).
  - mode_valid may be held high; a mode is accepted once per LOAD cycle.
- FSM states are IDLE, LOAD and RUN.
  - IDLE: leds=0. An accept → LOAD.
  - LOAD (exactly 1 cycle): at the next edge, leds ← seed(mode_r), prescaler ← 0, dir ← left, state ← RUN.
  - RUN: an accept → LOAD (re-seed). If mode_r is OFF or reserved, leds is held at 0 and no step_pulse is produced.
- Latency: accept at edge N → seed is visible on leds after edge N+1. With en=1 continuously, the first step is visible after edge N+1+TICK_DIV.
- Prescaler:
  - Counts only in RUN with en=1.
  - tick = (count == TICK_DIV-1); on a tick, count wraps to 0.
  - en=0 holds count and leds. When en returns to 1, counting resumes from the held count with no re-seed.
- Step on tick: leds ← next(leds), and step_pulse=1 for exactly that one cycle.
- BOUNCE:
  - Shift in the current direction.
  - When the result reaches the MSB set, dir ← right; when it reaches bit0 set, dir ← left.
  - The end LEDs are lit for one step each; there is no double dwell.
- Simultaneous tick and accept at the same edge: the accept wins, the tick is discarded, and step_pulse=0.
- Width rules:
  - All pattern arithmetic is LED_WIDTH bits; COUNT wraps from all-ones to 0.
  - The prescaler never exceeds TICK_DIV-1.
- Outputs are all registered; there is no combinational path from inputs to leds or step_pulse. mode_ready is decoded from state only.

Decomposition:
- Package `led_ctrl_pkg`:
  - mode code localparams (MODE_OFF, MODE_ROT_L, MODE_ROT_R, MODE_BOUNCE, MODE_BLINK, MODE_COUNT).
  - FSM state encoding (ST_IDLE, ST_LOAD, ST_RUN).
  - direction constants.
- Sub-module `led_tick_gen`:
  - parameters: TICK_DIV.
  - ports: clk, reset, clr, en; output tick.
  - Contains the prescaler counter; clr is driven in LOAD.
- The pattern next-state function stays inline in led_pattern_sequencer.

Test Plan:
All scenarios use LED_WIDTH=4 and TICK_DIV=4.
1. Reset: hold reset 3 cycles with mode_valid=1 → leds=0000, mode_ready=1, step_pulse=0, active=0 throughout; release → still IDLE until a handshake.
2. ROT_L with en=1: accept mode 1 at edge N → leds=0001 after edge N+1. Then leds=0010, 0100, 1000, 0001 at edges N+5, N+9, N+13, N+17, with step_pulse high exactly in those cycles.
3. BOUNCE: accept mode 3, run 8 steps → leds sequence 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010, 0100.
4. COUNT with en toggling: accept mode 5, run 2 steps (leds=0010), drop en for 10 cycles → leds stays 0010 and no step_pulse; raise en → next step 0011 exactly 4 − (held count) cycles later; continues to 1111 then 0000.
5. Handshake collision: in RUN ROT_R, assert mode_valid with mode 4 on the cycle tick fires → no step applied, mode_ready=0 next cycle, then leds=1111 and blinks 0000/1111 every 4 cycles.
6. Reserved mode and mid-run reset: accept mode 7 → leds=0000, active=0, no step_pulse; then run ROT_L and assert reset for 1 cycle mid-step → leds=0000, state IDLE next cycle, and the prescaler restarts from 0 after the next accept.
